floating_accumulator_32b: RTL
=============================

FLOATING_ACCUMULATOR_32B -- requirements
Module: floating_accumulator_32b

Interface
REQ-001 SHALL have parameter CLEAR_ON_OUT, default 1; when 1 the accumulator clears to +0.0 after each result handoff, when 0 it retains the sum.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-low (asserted when 0).
REQ-004 SHALL have port in_data, input, 32, IEEE-754 single-precision product from the upstream 32-bit floating multiplier.
REQ-005 SHALL have port in_ov, input, 1, overflow flag of the upstream multiplier, paired with in_data.
REQ-006 SHALL have port in_valid, input, 1, in_data/in_ov/in_last are valid.
REQ-007 SHALL have port in_last, input, 1, final product of the current accumulation group.
REQ-008 SHALL have port in_ready, output, 1, block accepts an operand this cycle.
REQ-009 SHALL have port sum, output, 32, accumulated single-precision result.
REQ-010 SHALL have port sum_ov, output, 1, sticky overflow for the group.
REQ-011 SHALL have port out_valid, output, 1, sum/sum_ov are valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the result.

Function
REQ-013 SHALL accept an operand when in_valid && in_ready are both 1 at a rising edge.
REQ-014 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, DONE; in_ready=1 only in IDLE.
REQ-015 SHALL transition IDLE->ALIGN on accept, ALIGN->ADD, ADD->NORM, NORM->DONE if the accepted operand had in_last=1, else NORM->IDLE; DONE->IDLE when out_ready=1.
REQ-016 SHALL give a fixed occupancy of 4 cycles per operand (accept edge to next in_ready=1), plus the DONE cycles for a last operand.
REQ-017 ALIGN SHALL compare exponents, swap so the larger-magnitude operand is A, and right-shift B's 24-bit significand (hidden bit restored) by the exponent difference with truncation; a difference >=24 SHALL make B zero.
REQ-018 ADD SHALL add significands when signs are equal, else subtract B from A, into a 25-bit result; the result sign SHALL be A's sign.
REQ-019 NORM SHALL right-shift by 1 with exponent+1 if bit 24 is set, else left-shift by the leading-zero count of bits 23:0 with the exponent reduced accordingly; it SHALL complete in one cycle.
REQ-020 An exact-zero result SHALL be encoded as +0.0 (32'h00000000).
REQ-021 Inputs with exponent 0 (zero/denormal) SHALL be flushed to zero; a normalized exponent <=0 SHALL produce +0.0.
REQ-022 A normalized exponent >=255 SHALL produce signed infinity (exponent 8'hFF, mantissa 0) and set sum_ov.
REQ-023 An input with exponent 8'hFF or in_ov=1 SHALL set sum_ov and force the accumulator to signed infinity of that input.
REQ-024 sum_ov SHALL be sticky across the group and SHALL clear together with the accumulator.
REQ-025 In DONE, out_valid=1 and sum/sum_ov SHALL hold stable until out_ready=1; out_ready outside DONE SHALL be ignored.
REQ-026 On the DONE->IDLE handoff, if CLEAR_ON_OUT=1 the accumulator SHALL become +0.0 and sum_ov 0 on the same edge.
REQ-027 The sum output SHALL reflect the accumulator register at all times; out_valid=0 outside DONE.

Reset
REQ-028 When rst=0 at a rising edge: state=IDLE, accumulator=+0.0, sum=0, sum_ov=0, out_valid=0, in_ready=1 on the following cycle.
REQ-029 A reset asserted in any state, including mid-operation, SHALL discard the in-flight operand with no partial update.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding and the constants EXP_BIAS=127, EXP_MAX=255, MANT_W=23.
REQ-031 The leading-zero counter SHALL be a sub-module named fp_lzc24 (24-bit input, 5-bit count).

Verification
REQ-032 1.0 (3F800000), then 2.0 (40000000) with in_last=1 -> sum=40400000, sum_ov=0, out_valid exactly 4 cycles after the second accept.
REQ-033 1.5 (3FC00000), then -1.5 (BFC00000) with in_last=1 -> sum=00000000 (+0.0).
REQ-034 7F7FFFFF twice with the second in_last=1 -> sum=7F800000, sum_ov=1; the next group starting from 3F800000 with in_last=1 -> sum=3F800000, sum_ov=0.
REQ-035 in_ov=1 on the first of three operands -> sum_ov=1 at DONE regardless of the later values.
REQ-036 out_ready held 0 for 5 cycles in DONE -> out_valid=1, sum stable, in_ready=0 throughout; handoff on the 6th cycle.
REQ-037 rst=0 during ADD -> next cycle state IDLE, in_ready=1, sum=00000000, out_valid=0.

Source files
------------

// File: rtl/floating_accumulator_32b_pkg.sv
// Shared FSM encoding, IEEE-754 single-precision constants and small field helpers
// for the floating accumulator.
package floating_accumulator_32b_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int MANT_W   = 23;

    // Signed infinity with the given sign.
    function automatic logic [31:0] fp_inf(input logic sign);
        return {sign, 8'hFF, 23'h000000};
    endfunction

    // 24-bit significand with hidden bit; zero/denormal inputs flush to zero.
    function automatic logic [MANT_W:0] fp_sig(input logic [31:0] f);
        return (f[30:23] == 8'h00) ? 24'h000000 : {1'b1, f[MANT_W-1:0]};
    endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Leading-zero counter for a 24-bit significand; an all-zero input reports 24.
module fp_lzc24 (
    input  logic [23:0] val,
    output logic [4:0]  cnt
);

    // Scan upward so the most significant set bit decides the final count.
    always_comb begin
        cnt = 5'd24;
        for (int i = 0; i < 24; i++) begin
            cnt = val[i] ? 5'(5'd23 - 5'(i)) : cnt;
        end
    end

endmodule

// File: rtl/floating_accumulator_32b.sv
// Single-precision accumulator fed by an upstream multiplier; each operand walks
// ALIGN -> ADD -> NORM, and a group's last operand parks the result in DONE.
module floating_accumulator_32b
    import floating_accumulator_32b_pkg::*;
#(
    parameter bit CLEAR_ON_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_ov,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] sum,
    output logic        sum_ov,
    output logic        out_valid,
    input  logic        out_ready
);

    state_t      state_r, state_s;
    logic [31:0] op_r, acc_r;
    logic        op_ov_r, op_last_r, acc_ov_r;
    logic        a_sign_r, eff_sub_r;
    logic [7:0]  a_exp_r;
    logic [23:0] a_sig_r, b_sig_r;
    logic [24:0] sum25_r;

    logic [31:0] op_flush_s, acc_flush_s, big_s, small_s, acc_next_s;
    logic        swap_s, op_spec_s, ov_set_s;
    logic [7:0]  diff_s;
    logic [23:0] shifted_s, norm_sig_s;
    logic [24:0] add_s;
    logic [4:0]  lz_s;
    logic signed [9:0] norm_exp_s;

    fp_lzc24 u_lzc (
        .val (sum25_r[23:0]),
        .cnt (lz_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = in_valid ? ST_ALIGN : ST_IDLE;
            ST_ALIGN: state_s = ST_ADD;
            ST_ADD:   state_s = ST_NORM;
            ST_NORM:  state_s = op_last_r ? ST_DONE : ST_IDLE;
            ST_DONE:  state_s = out_ready ? ST_IDLE : ST_DONE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = (state_r == ST_IDLE);
        out_valid = (state_r == ST_DONE);
    end

    assign sum    = acc_r;
    assign sum_ov = acc_ov_r;

    // Alignment: the larger magnitude becomes A, B is shifted right with truncation.
    always_comb begin
        op_flush_s  = (op_r[30:23] == 8'h00) ? {op_r[31], 31'h0} : op_r;
        acc_flush_s = (acc_r[30:23] == 8'h00) ? {acc_r[31], 31'h0} : acc_r;
        swap_s      = (op_flush_s[30:0] > acc_flush_s[30:0]);
        big_s       = swap_s ? op_flush_s : acc_flush_s;
        small_s     = swap_s ? acc_flush_s : op_flush_s;
        diff_s      = big_s[30:23] - small_s[30:23];
        shifted_s   = (diff_s >= 8'd24) ? 24'h000000 : (fp_sig(small_s) >> diff_s);
        add_s       = eff_sub_r ? ({1'b0, a_sig_r} - {1'b0, b_sig_r})
                                : ({1'b0, a_sig_r} + {1'b0, b_sig_r});
    end

    // Normalisation and packing; special operands override the arithmetic result.
    always_comb begin
        op_spec_s = (op_r[30:23] == 8'hFF) || op_ov_r;
        ov_set_s  = 1'b0;
        if (sum25_r[24]) begin
            norm_sig_s = sum25_r[24:1];
            norm_exp_s = $signed({2'b00, a_exp_r}) + 10'sd1;
        end else begin
            norm_sig_s = sum25_r[23:0] << lz_s;
            norm_exp_s = $signed({2'b00, a_exp_r}) - $signed({5'b00000, lz_s});
        end
        if (op_spec_s) begin
            acc_next_s = fp_inf(op_r[31]);
            ov_set_s   = 1'b1;
        end else if (sum25_r == 25'd0) begin
            acc_next_s = 32'h00000000;
        end else if (norm_exp_s >= $signed(10'(EXP_MAX))) begin
            acc_next_s = fp_inf(a_sign_r);
            ov_set_s   = 1'b1;
        end else if (norm_exp_s <= 10'sd0) begin
            acc_next_s = 32'h00000000;
        end else begin
            acc_next_s = {a_sign_r, norm_exp_s[7:0], norm_sig_s[MANT_W-1:0]};
        end
    end

    // Datapath registers; the accumulator only changes in NORM, so a reset mid-flight leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_r      <= 32'h00000000;
            op_ov_r   <= 1'b0;
            op_last_r <= 1'b0;
            a_sign_r  <= 1'b0;
            a_exp_r   <= 8'h00;
            a_sig_r   <= 24'h000000;
            b_sig_r   <= 24'h000000;
            eff_sub_r <= 1'b0;
            sum25_r   <= 25'd0;
            acc_r     <= 32'h00000000;
            acc_ov_r  <= 1'b0;
        end else begin
            if (state_r == ST_IDLE && in_valid) begin
                op_r      <= in_data;
                op_ov_r   <= in_ov;
                op_last_r <= in_last;
            end
            if (state_r == ST_ALIGN) begin
                a_sign_r  <= big_s[31];
                a_exp_r   <= big_s[30:23];
                a_sig_r   <= fp_sig(big_s);
                b_sig_r   <= shifted_s;
                eff_sub_r <= big_s[31] ^ small_s[31];
            end
            if (state_r == ST_ADD) begin
                sum25_r <= add_s;
            end
            if (state_r == ST_NORM) begin
                acc_r    <= acc_next_s;
                acc_ov_r <= acc_ov_r | ov_set_s;
            end else if (state_r == ST_DONE && out_ready && CLEAR_ON_OUT) begin
                acc_r    <= 32'h00000000;
                acc_ov_r <= 1'b0;
            end
        end
    end

endmodule
